// File: rtl/mips_core.sv
// mips_core: single-cycle MIPS-I subset core with optional branch delay slot (MIPS_CORE_DELAY_SLOT_EN)
//   clk, reset (sync, active-low); instr_addr/instr_in: fetch port; data_addr/data_in/data_out/data_rd_wr: load/store port
module mips_core_regfile #(
  parameter logic [31:0] sp_init = 32'h80120000,
  parameter logic [31:0] ra_init = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] data [0:31];
  assign rd1 = data[ra1];
  assign rd2 = data[ra2];
  always_ff @(posedge clk)
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        data[i] <= i == 29 ? sp_init : i == 31 ? ra_init : 32'h0;
    end else if (we && wa != 5'd0) data[wa] <= wd;
endmodule

module mips_core #(
  parameter logic [31:0] pc_init = 32'h80020000,
  parameter logic [31:0] sp_init = 32'h80120000,
  parameter logic [31:0] ra_init = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_in,
  output logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_rd_wr
);
  logic [31:0] pc, a, b, pc4, link, sext, zext, wd, target;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh, wa;
  logic        we, taken;
  assign op   = instr_in[31:26];
  assign rs   = instr_in[25:21];
  assign rt   = instr_in[20:16];
  assign rd   = instr_in[15:11];
  assign sh   = instr_in[10:6];
  assign fn   = instr_in[5:0];
  assign sext = {{16{instr_in[15]}}, instr_in[15:0]};
  assign zext = {16'h0, instr_in[15:0]};
  assign pc4  = pc + 32'd4;
`ifdef MIPS_CORE_DELAY_SLOT_EN
  assign link = pc + 32'd8;
`else
  assign link = pc4;
`endif
  mips_core_regfile #(.sp_init(sp_init), .ra_init(ra_init)) regs (
    .clk(clk), .reset(reset), .ra1(rs), .ra2(rt), .we(we && reset), .wa(wa), .wd(wd), .rd1(a), .rd2(b)
  );
  // Reset overrides the fetch address so memory sees pc_init even before the first edge.
  assign instr_addr = reset ? pc : pc_init;
  assign data_addr  = a + sext;
  assign data_out   = b;
  assign data_rd_wr = !(reset && op == 6'h2b);
  always_comb begin
    we = 1'b0;
    wa = rt;
    wd = 32'h0;
    taken = 1'b0;
    target = pc4 + {sext[29:0], 2'b00};
    case (op)
      6'h00: begin
        wa = rd;
        we = 1'b1;
        case (fn)
          6'h21: wd = a + b;
          6'h23: wd = a - b;
          6'h24: wd = a & b;
          6'h25: wd = a | b;
          6'h26: wd = a ^ b;
          6'h27: wd = ~(a | b);
          6'h2a: wd = {31'h0, $signed(a) < $signed(b)};
          6'h2b: wd = {31'h0, a < b};
          6'h00: wd = b << sh;
          6'h02: wd = b >> sh;
          6'h03: wd = $signed(b) >>> sh;
          6'h08: begin we = 1'b0; taken = 1'b1; target = a; end
          6'h09: begin taken = 1'b1; target = a; wd = link; end
          default: we = 1'b0;
        endcase
      end
      6'h09: begin we = 1'b1; wd = a + sext; end
      6'h0c: begin we = 1'b1; wd = a & zext; end
      6'h0d: begin we = 1'b1; wd = a | zext; end
      6'h0e: begin we = 1'b1; wd = a ^ zext; end
      6'h0a: begin we = 1'b1; wd = {31'h0, $signed(a) < $signed(sext)}; end
      6'h0b: begin we = 1'b1; wd = {31'h0, a < sext}; end
      6'h0f: begin we = 1'b1; wd = {instr_in[15:0], 16'h0}; end
      6'h23: begin we = 1'b1; wd = data_in; end
      6'h04: taken = a == b;
      6'h05: taken = a != b;
      6'h06: taken = $signed(a) <= 0;
      6'h07: taken = $signed(a) > 0;
      6'h02: begin taken = 1'b1; target = {pc4[31:28], instr_in[25:0], 2'b00}; end
      6'h03: begin taken = 1'b1; target = {pc4[31:28], instr_in[25:0], 2'b00}; we = 1'b1; wa = 5'd31; wd = link; end
      default: ;
    endcase
  end
`ifdef MIPS_CORE_DELAY_SLOT_EN
  logic        pend_v;
  logic [31:0] pend_t;
  always_ff @(posedge clk)
    if (!reset) begin
      pc <= pc_init;
      pend_v <= 1'b0;
      pend_t <= 32'h0;
    end else begin
      pc <= pend_v ? pend_t : pc4;
      pend_v <= taken;
      pend_t <= {target[31:2], 2'b00};
    end
`else
  always_ff @(posedge clk)
    if (!reset) pc <= pc_init;
    else pc <= taken ? {target[31:2], 2'b00} : pc4;
`endif
endmodule

// File: tb/tb_mips_core.sv
// tb_mips_core: scoreboard bench for mips_core; expectations are queued per cycle and checked by a negedge monitor
module tb_mips_core;
  logic clk, reset, data_rd_wr;
  logic [31:0] instr_addr, instr_in, data_addr, data_in, data_out;
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:15];
  int cyc = 0, base = 0, checks = 0, errors = 0;
  typedef struct {int cyc; int kind; int idx; logic [31:0] val; string name;} exp_t;
  exp_t q[$];

  mips_core dut (
    .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr_in(instr_in),
    .data_addr(data_addr), .data_in(data_in), .data_out(data_out), .data_rd_wr(data_rd_wr)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign instr_in = instr_addr[31:8] == 24'h800200 ? imem[instr_addr[7:2]] : 32'h0;
  assign data_in  = dmem[data_addr[5:2]];
  always @(posedge clk) if (!data_rd_wr) dmem[data_addr[5:2]] <= data_out;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      act = e.kind == 0 ? instr_addr : e.kind == 1 ? {31'h0, data_rd_wr} :
            e.kind == 2 ? data_addr : e.kind == 3 ? data_out : dut.regs.data[e.idx];
      checks++;
      if (act !== e.val || e.cyc != cyc) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %h expected %h", e.name, cyc - base, act, e.val);
      end
    end
  end

  task automatic ex(int k, int kind, int idx, logic [31:0] v, string nm);
    q.push_back('{base + k, kind, idx, v, nm});
  endtask

  task automatic start();
    @(posedge clk); #2;
    foreach (imem[i]) imem[i] = 32'h0;
    foreach (dmem[i]) dmem[i] = 32'h0;
    reset = 0;
    base = cyc;
  endtask

  task automatic run(int n);
    @(posedge clk); #2;
    reset = 1;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    reset = 0;
    start();
    imem[0] = 32'h24020005; imem[1] = 32'h24030007; imem[2] = 32'h00431021; imem[3] = 32'h24000009;
    imem[4] = 32'h3C02DEAD; imem[5] = 32'h3442BEEF; imem[6] = 32'hAFA20000; imem[7] = 32'h8FA30000;
    imem[8] = 32'h00032023; imem[9] = 32'h0083282B; imem[10] = 32'h00033103; imem[11] = 32'h03E00008;
    ex(0, 0, 0, 32'h80020000, "reset_ia");
    ex(0, 1, 0, 32'h1, "reset_rdwr");
    ex(1, 4, 29, 32'h80120000, "reset_r29");
    ex(1, 4, 31, 32'h0, "reset_r31");
    ex(1, 0, 0, 32'h80020000, "first_ia");
    ex(2, 0, 0, 32'h80020004, "ia_plus4");
    ex(2, 4, 2, 32'h5, "addiu_r2");
    ex(3, 4, 3, 32'h7, "addiu_r3");
    ex(3, 0, 0, 32'h80020008, "ia_plus8");
    ex(4, 4, 2, 32'hC, "addu_r2");
    ex(5, 4, 0, 32'h0, "r0_ignored");
    ex(6, 1, 0, 32'h1, "rdwr_nonsw");
    ex(7, 4, 2, 32'hDEADBEEF, "lui_ori_r2");
    ex(7, 1, 0, 32'h0, "sw_rdwr");
    ex(7, 2, 0, 32'h80120000, "sw_addr");
    ex(7, 3, 0, 32'hDEADBEEF, "sw_data");
    ex(8, 1, 0, 32'h1, "lw_rdwr");
    ex(9, 4, 3, 32'hDEADBEEF, "lw_r3");
    ex(10, 4, 4, 32'h21524111, "subu_r4");
    ex(11, 4, 5, 32'h1, "sltu_r5");
    ex(12, 4, 6, 32'hFDEADBEE, "sra_r6");
`ifdef MIPS_CORE_DELAY_SLOT_EN
    ex(13, 0, 0, 32'h80020030, "jr_delay_ia");
    ex(14, 0, 0, 32'h0, "jr_end_ia");
`else
    ex(13, 0, 0, 32'h0, "jr_end_ia");
`endif
    run(16);
    checks++;
    if (dut.regs.data[2] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL final_r2: got %h expected DEADBEEF", dut.regs.data[2]);
    end
    checks++;
    if (dut.regs.data[3] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL final_r3: got %h expected DEADBEEF", dut.regs.data[3]);
    end
    start();
    imem[0] = 32'h10000003; imem[1] = 32'h24070001; imem[2] = 32'h24080001; imem[3] = 32'h24080001;
    imem[4] = 32'h24090002; imem[5] = 32'h0C008008; imem[6] = 32'h240A0003; imem[8] = 32'h240B0004;
    ex(1, 0, 0, 32'h80020000, "beq_ia");
`ifdef MIPS_CORE_DELAY_SLOT_EN
    ex(2, 0, 0, 32'h80020004, "beq_slot_ia");
    ex(3, 0, 0, 32'h80020010, "beq_target_ia");
    ex(3, 4, 7, 32'h1, "slot_r7");
    ex(5, 0, 0, 32'h80020018, "jal_slot_ia");
    ex(6, 0, 0, 32'h80020020, "jal_target_ia");
    ex(6, 4, 31, 32'h8002001C, "jal_link");
    ex(6, 4, 10, 32'h3, "jal_slot_r10");
    ex(7, 4, 11, 32'h4, "target_r11");
    ex(7, 4, 8, 32'h0, "skipped_r8");
`else
    ex(2, 0, 0, 32'h80020010, "beq_target_ia");
    ex(3, 0, 0, 32'h80020014, "jal_ia");
    ex(4, 0, 0, 32'h80020020, "jal_target_ia");
    ex(4, 4, 31, 32'h80020018, "jal_link");
    ex(5, 4, 11, 32'h4, "target_r11");
    ex(5, 4, 7, 32'h0, "skipped_r7");
    ex(5, 4, 8, 32'h0, "skipped_r8");
    ex(5, 4, 10, 32'h0, "skipped_r10");
`endif
    ex(5, 4, 9, 32'h2, "target_r9");
    run(10);
    repeat (2) @(posedge clk);
    checks++;
    if (dut.regs.data[9] !== 32'h2) begin
      errors++;
      $display("FAIL final_r9: got %h expected 00000002", dut.regs.data[9]);
    end
    checks++;
    if (dut.regs.data[0] !== 32'h0) begin
      errors++;
      $display("FAIL final_r0: got %h expected 00000000", dut.regs.data[0]);
    end
    checks++;
    if (dut.regs.data[29] !== 32'h80120000) begin
      errors++;
      $display("FAIL final_r29: got %h expected 80120000", dut.regs.data[29]);
    end
    foreach (q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: never checked, expected %h", q[i].name, q[i].val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_core.md
MIPS_CORE -- requirements
Module: mips_core

Interface
REQ-001 SHALL have parameter pc_init, default 32'h80020000, PC value loaded at reset.
REQ-002 SHALL have parameter sp_init, default 32'h80120000, r29 value loaded at reset.
REQ-003 SHALL have parameter ra_init, default 32'h00000000, r31 value loaded at reset.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port instr_addr, output, 32 bits: byte address of the current instruction (equal to PC).
REQ-007 SHALL have port instr_in, input, 32 bits: instruction word at instr_addr, valid combinationally in the same cycle.
REQ-008 SHALL have port data_addr, output, 32 bits: byte address for load/store.
REQ-009 SHALL have port data_in, input, 32 bits: load data at data_addr, valid combinationally in the same cycle.
REQ-010 SHALL have port data_out, output, 32 bits: store data.
REQ-011 SHALL have port data_rd_wr, output, 1 bit: 1 = read, 0 = write (memory captures the write on the clock edge).

Function
REQ-012 SHALL be a single-cycle core: one instruction fetched, executed and retired per clk cycle.
REQ-013 SHALL contain a register file instance named regs holding array data[0:31] of 32-bit words; data[0] SHALL always read 0, and writes to it SHALL be ignored.
REQ-014 SHALL implement ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, JR, JALR (R-type) and ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE, BLEZ, BGTZ, J, JAL.
REQ-015 SHALL use 32-bit wrap-around arithmetic with no overflow exceptions; ADDIU/SLTI/SLTIU/LW/SW/branch offsets SHALL sign-extend imm16; ANDI/ORI/XORI SHALL zero-extend it.
REQ-016 SHALL form the branch target as PC+4+(sext(imm16)<<2) and the jump target as {PC+4[31:28], instr[25:0], 2'b00}.
REQ-017 SHALL make JAL/JALR write the link address (the address after the delay slot when REQ-027 applies, else PC+4) into r31 (rd for JALR).
REQ-018 SHALL drive data_rd_wr=0 only during a SW cycle, with data_addr=rs+sext(imm) and data_out=rt; in all other cycles data_rd_wr SHALL be 1.
REQ-019 SHALL make LW write data_in into rt at the end of the same cycle.
REQ-020 SHALL treat unsupported or undefined opcodes as NOP (PC advances by 4, no state change).
REQ-021 SHALL ignore bits [1:0] of word addresses; unaligned access is not detected.

Reset
REQ-022 SHALL, while reset=0 at a rising edge, load PC=pc_init, data[29]=sp_init, data[31]=ra_init and all other registers 0.
REQ-023 SHALL, during reset, drive instr_addr=pc_init and data_rd_wr=1, and SHALL perform no memory writes.
REQ-024 SHALL, when reset is asserted mid-program, abandon the current instruction (including any pending branch) without writing any architectural state.
REQ-025 SHALL execute the instruction at pc_init in the first cycle after reset is released.

Configuration
REQ-026 SHALL use macro MIPS_CORE_DELAY_SLOT_EN to select branch-delay-slot behaviour.
REQ-027 SHALL, with MIPS_CORE_DELAY_SLOT_EN defined, always execute the instruction following a taken branch/jump before the target (a one-entry pending-target register), with the link address = PC+8.
REQ-028 SHALL, without MIPS_CORE_DELAY_SLOT_EN, load the target directly into PC in the cycle after a taken branch/jump, with the link address = PC+4.

Verification
REQ-029 SHALL be verified with this scenario: hold reset=0 for one cycle -> instr_addr=80020000, r29=80120000, r31=0, data_rd_wr=1.
REQ-030 SHALL be verified with this scenario: ADDIU r2,r0,5; ADDIU r3,r0,7; ADDU r2,r2,r3 -> r2=0000000C, r3=00000007, PC advances by 4 per cycle.
REQ-031 SHALL be verified with this scenario: SW r2,0(r29) then LW r3,0(r29) with r2=DEADBEEF -> data_rd_wr=0 for exactly one cycle at data_addr=80120000, then r3=DEADBEEF.
REQ-032 SHALL be verified with this scenario: BEQ r0,r0,+3 at 80020000 -> with macro: next PCs 80020004 then 80020010; without macro: next PC 80020010.
REQ-033 SHALL be verified with this scenario: JR r31 with ra_init=0 -> instr_addr reaches 00000000 (program-end condition).
REQ-034 SHALL be verified with this scenario: ADDIU r0,r0,9 -> data[0] remains 0.
